// File: rtl/sirv_qspi_target_media.sv
// SPI/QSPI target link layer: oversamples SCK/CS/DQ on the system clock,
// deserialises received bytes and serialises held tx bytes back to the initiator.
module sirv_qspi_target_media #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_port_sck,
  input  logic       io_port_cs_0,
  input  logic       io_port_dq_0_i,
  input  logic       io_port_dq_1_i,
  input  logic       io_port_dq_2_i,
  input  logic       io_port_dq_3_i,
  output logic       io_port_dq_0_o,
  output logic       io_port_dq_1_o,
  output logic       io_port_dq_2_o,
  output logic       io_port_dq_3_o,
  output logic       io_port_dq_0_oe,
  output logic       io_port_dq_1_oe,
  output logic       io_port_dq_2_oe,
  output logic       io_port_dq_3_oe,
  input  logic       io_ctrl_sck_pol,
  input  logic       io_ctrl_sck_pha,
  input  logic [1:0] io_ctrl_fmt_proto,
  input  logic       io_ctrl_fmt_endian,
  input  logic       io_ctrl_fmt_iodir,
  input  logic       io_link_tx_valid,
  input  logic [7:0] io_link_tx_bits,
  output logic       io_link_tx_ready,
  output logic       io_link_rx_valid,
  output logic [7:0] io_link_rx_bits,
  output logic       io_link_active,
  output logic       io_link_underrun,
  output logic       io_link_partial
);

  localparam int unsigned NIN      = 6;
  localparam logic [NIN-1:0] SYNC_RST = 6'b00_0010;  // cs idles high
  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_DUAL   = 2'd1;
  localparam logic [1:0] M_QUAD   = 2'd2;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  logic [NIN-1:0] sync_q [SYNC_STAGES];
  logic [NIN-1:0] raw_in, synced;
  logic           sck_s, cs_s;
  logic [3:0]     dq_s;

  state_e     state_q, state_d;
  logic       sck_prev_q, cs_prev_q;
  logic       pol_q, pol_d, pha_q, pha_d, endian_q, endian_d, iodir_q, iodir_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_bits_q, rx_bits_d;
  logic       rx_done_q, rx_done_d, rx_valid_q, rx_valid_d;
  logic       seen_q, seen_d, bnd_q, bnd_d;
  logic [7:0] hold_q, hold_d, tx_sh_q, tx_sh_d;
  logic       empty_q, empty_d, underrun_q, underrun_d, partial_q, partial_d;
  logic [3:0] dq_o_q, dq_o_d, dq_oe_q, dq_oe_d;

  logic       lead, trail, start, rx_en, samp, drv, accept, load;
  logic [3:0] kbits, sum, oe_mask, out_bits;
  logic [7:0] rx_next, tx_adv;

  assign raw_in = {io_port_dq_3_i, io_port_dq_2_i, io_port_dq_1_i, io_port_dq_0_i,
                   io_port_cs_0, io_port_sck};
  assign synced = sync_q[SYNC_STAGES-1];
  assign sck_s  = synced[0];
  assign cs_s   = synced[1];
  assign dq_s   = synced[5:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= raw_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign lead  = (sck_prev_q == pol_q) && (sck_s == ~pol_q);
  assign trail = (sck_prev_q == ~pol_q) && (sck_s == pol_q);
  assign start = (state_q == ST_IDLE) && cs_prev_q && !cs_s;
  assign rx_en = (mode_q == M_SINGLE) || !iodir_q;
  // CS release suppresses any same-cycle SCK edge
  assign samp  = (state_q == ST_ACTIVE) && !cs_s && (pha_q ? trail : lead);
  assign drv   = (state_q == ST_ACTIVE) && !cs_s && (pha_q ? lead : trail);
  assign sum   = {1'b0, cnt_q} + kbits;

  // Lane grouping: lowest lane is the least significant bit of each group
  always_comb begin
    kbits   = 4'd1;
    rx_next = endian_q ? {dq_s[0], rx_sh_q[7:1]} : {rx_sh_q[6:0], dq_s[0]};
    tx_adv  = endian_q ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
    case (mode_q)
      M_DUAL: begin
        kbits   = 4'd2;
        rx_next = endian_q ? {dq_s[1:0], rx_sh_q[7:2]} : {rx_sh_q[5:0], dq_s[1:0]};
        tx_adv  = endian_q ? {2'b0, tx_sh_q[7:2]} : {tx_sh_q[5:0], 2'b0};
      end
      M_QUAD: begin
        kbits   = 4'd4;
        rx_next = endian_q ? {dq_s[3:0], rx_sh_q[7:4]} : {rx_sh_q[3:0], dq_s[3:0]};
        tx_adv  = endian_q ? {4'b0, tx_sh_q[7:4]} : {tx_sh_q[3:0], 4'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pol_d      = pol_q;
    pha_d      = pha_q;
    endian_d   = endian_q;
    iodir_d    = iodir_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_bits_d  = rx_bits_q;
    rx_done_d  = 1'b0;
    rx_valid_d = 1'b0;
    seen_d     = seen_q;
    bnd_d      = bnd_q;
    hold_d     = hold_q;
    empty_d    = empty_q;
    tx_sh_d    = tx_sh_q;
    underrun_d = 1'b0;
    partial_d  = 1'b0;
    load       = 1'b0;
    accept     = io_link_tx_valid && empty_q;
    oe_mask    = 4'b0;
    out_bits   = 4'b0;

    if (rx_done_q) begin
      rx_valid_d = 1'b1;
      rx_bits_d  = rx_sh_q;
    end
    if (accept) begin
      hold_d  = io_link_tx_bits;
      empty_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACTIVE;
          pol_d    = io_ctrl_sck_pol;
          pha_d    = io_ctrl_sck_pha;
          endian_d = io_ctrl_fmt_endian;
          iodir_d  = io_ctrl_fmt_iodir;
          mode_d   = (io_ctrl_fmt_proto == 2'd1) ? M_DUAL :
                     (io_ctrl_fmt_proto == 2'd2) ? M_QUAD : M_SINGLE;
          cnt_d    = 3'd0;
          seen_d   = 1'b0;
          bnd_d    = 1'b0;
          load     = 1'b1;
        end
      end
      default: begin
        if (cs_s) begin
          state_d   = ST_IDLE;
          partial_d = (cnt_q != 3'd0);
          cnt_d     = 3'd0;
          bnd_d     = 1'b0;
          tx_sh_d   = 8'h00;
        end else if (samp) begin
          cnt_d     = sum[2:0];
          rx_sh_d   = rx_next;
          seen_d    = 1'b1;
          bnd_d     = sum[3];
          rx_done_d = sum[3] && rx_en;
        end else if (drv && seen_q) begin
          if (bnd_q) begin
            load  = 1'b1;
            bnd_d = 1'b0;
          end else begin
            tx_sh_d = tx_adv;
          end
        end
      end
    endcase

    // Shifter load; a same-cycle accept refills holding with the new byte
    if (load) begin
      if (!empty_q) begin
        tx_sh_d = hold_q;
        if (!accept) empty_d = 1'b1;
      end else begin
        tx_sh_d    = UNDERRUN_BYTE;
        underrun_d = 1'b1;
      end
    end

    case (mode_d)
      M_DUAL: begin
        oe_mask  = iodir_d ? 4'b0011 : 4'b0000;
        out_bits = endian_d ? {2'b0, tx_sh_d[1:0]} : {2'b0, tx_sh_d[7:6]};
      end
      M_QUAD: begin
        oe_mask  = iodir_d ? 4'b1111 : 4'b0000;
        out_bits = endian_d ? tx_sh_d[3:0] : tx_sh_d[7:4];
      end
      default: begin
        oe_mask  = 4'b0010;
        out_bits = {2'b0, endian_d ? tx_sh_d[0] : tx_sh_d[7], 1'b0};
      end
    endcase
    dq_oe_d = (state_d == ST_ACTIVE) ? oe_mask : 4'b0;
    dq_o_d  = out_bits & dq_oe_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      pol_q      <= 1'b0;
      pha_q      <= 1'b0;
      endian_q   <= 1'b0;
      iodir_q    <= 1'b0;
      mode_q     <= M_SINGLE;
      cnt_q      <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_bits_q  <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      seen_q     <= 1'b0;
      bnd_q      <= 1'b0;
      hold_q     <= 8'h00;
      empty_q    <= 1'b1;
      tx_sh_q    <= 8'h00;
      underrun_q <= 1'b0;
      partial_q  <= 1'b0;
      dq_o_q     <= 4'b0;
      dq_oe_q    <= 4'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      pol_q      <= pol_d;
      pha_q      <= pha_d;
      endian_q   <= endian_d;
      iodir_q    <= iodir_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_bits_q  <= rx_bits_d;
      rx_done_q  <= rx_done_d;
      rx_valid_q <= rx_valid_d;
      seen_q     <= seen_d;
      bnd_q      <= bnd_d;
      hold_q     <= hold_d;
      empty_q    <= empty_d;
      tx_sh_q    <= tx_sh_d;
      underrun_q <= underrun_d;
      partial_q  <= partial_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign io_port_dq_0_o   = dq_o_q[0];
  assign io_port_dq_1_o   = dq_o_q[1];
  assign io_port_dq_2_o   = dq_o_q[2];
  assign io_port_dq_3_o   = dq_o_q[3];
  assign io_port_dq_0_oe  = dq_oe_q[0];
  assign io_port_dq_1_oe  = dq_oe_q[1];
  assign io_port_dq_2_oe  = dq_oe_q[2];
  assign io_port_dq_3_oe  = dq_oe_q[3];
  assign io_link_tx_ready = empty_q;
  assign io_link_rx_valid = rx_valid_q;
  assign io_link_rx_bits  = rx_bits_q;
  assign io_link_active   = (state_q == ST_ACTIVE);
  assign io_link_underrun = underrun_q;
  assign io_link_partial  = partial_q;

endmodule

// File: tb/tb_sirv_qspi_target_media.sv
// Bench for sirv_qspi_target_media: drives an SPI/QSPI initiator and checks
// rx bytes, returned tx bytes, enables and status pulses against a frame-level model.
module tb_sirv_qspi_target_media;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] dq_i = 4'b0;
  logic       pol = 1'b0, pha = 1'b0, endian = 1'b0, iodir = 1'b0;
  logic [1:0] proto = 2'd0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_bits = 8'h00;
  logic [3:0] dut_o, dut_oe;
  logic       tx_ready, rx_valid, active, underrun, partial;
  logic [7:0] rx_bits;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] mosi [0:3];
  logic [7:0] rx_exp [$];
  logic [7:0] exp_tx [$];
  logic [7:0] cap [0:3];
  int         cap_n = 0;
  bit         hold_full = 1'b0;
  logic [7:0] hold_byte = 8'h00;
  int         exp_und = 0, exp_par = 0;
  int         dut_und = 0, dut_par = 0, rx_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  logic [3:0] cfg_oe = 4'b0;
  logic [3:0] exp_oe_now;
  int         und0, rx0;

  always #5 clk = ~clk;

  sirv_qspi_target_media dut (
    .clock(clk), .reset(rst),
    .io_port_sck(sck), .io_port_cs_0(cs),
    .io_port_dq_0_i(dq_i[0]), .io_port_dq_1_i(dq_i[1]),
    .io_port_dq_2_i(dq_i[2]), .io_port_dq_3_i(dq_i[3]),
    .io_port_dq_0_o(dut_o[0]), .io_port_dq_1_o(dut_o[1]),
    .io_port_dq_2_o(dut_o[2]), .io_port_dq_3_o(dut_o[3]),
    .io_port_dq_0_oe(dut_oe[0]), .io_port_dq_1_oe(dut_oe[1]),
    .io_port_dq_2_oe(dut_oe[2]), .io_port_dq_3_oe(dut_oe[3]),
    .io_ctrl_sck_pol(pol), .io_ctrl_sck_pha(pha),
    .io_ctrl_fmt_proto(proto), .io_ctrl_fmt_endian(endian), .io_ctrl_fmt_iodir(iodir),
    .io_link_tx_valid(tx_valid), .io_link_tx_bits(tx_bits), .io_link_tx_ready(tx_ready),
    .io_link_rx_valid(rx_valid), .io_link_rx_bits(rx_bits),
    .io_link_active(active), .io_link_underrun(underrun), .io_link_partial(partial)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  // Every-cycle compare of enables and rx stream against the model
  always @(negedge clk) begin
    exp_oe_now = active ? cfg_oe : 4'b0;
    chk("oe", 32'(dut_oe), 32'(exp_oe_now));
    if (rx_valid) begin
      rx_cnt++;
      last_rx = rx_bits;
      if (rx_exp.size() == 0) fail("rx_unexpected", 32'(rx_bits));
      else chk("rx_bits", 32'(rx_bits), 32'(rx_exp.pop_front()));
    end
    if (underrun) dut_und++;
    if (partial) dut_par++;
  end

  task automatic model_load();
    if (hold_full) begin
      exp_tx.push_back(hold_byte);
      hold_full = 1'b0;
    end else begin
      exp_tx.push_back(8'hFF);
      exp_und++;
    end
  endtask

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    chk("tx_ready_idle", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_bits  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_full", 32'(tx_ready), 32'd0);
    hold_full = 1'b1;
    hold_byte = b;
  endtask

  function automatic logic [3:0] tx_group(input int g, input int k, input logic e);
    int b, j;
    logic [7:0] d, s;
    b = (g * k) / 8;
    j = ((g * k) % 8) / k;
    d = mosi[b];
    s = e ? (d >> (k * j)) : (d >> (8 - k * (j + 1)));
    return s[3:0] & 4'((1 << k) - 1);
  endfunction

  task automatic run_frame(input logic p_pol, input logic p_pha, input logic [1:0] p_proto,
                           input logic p_end, input logic p_dir, input int nbits, input int h,
                           input bit chk_tx, input int abort_at);
    int k, ng, bits;
    bit rx_en, pend;
    logic [3:0] mask, grp, grp_o;
    logic [7:0] cb;
    k     = (p_proto == 2'd1) ? 2 : (p_proto == 2'd2) ? 4 : 1;
    mask  = 4'((1 << k) - 1);
    rx_en = (k == 1) || !p_dir;
    @(negedge clk);
    pol = p_pol; pha = p_pha; proto = p_proto; endian = p_end; iodir = p_dir;
    cfg_oe = (k == 1) ? 4'b0010 : (p_dir ? mask : 4'b0000);
    sck = p_pol;
    repeat (4) @(negedge clk);
    exp_tx.delete();
    cap_n = 0; bits = 0; pend = 1'b0; cb = 8'h00;
    cs = 1'b0;
    model_load();
    ng = nbits / k;
    for (int g = 0; g < ng; g++) begin
      grp = tx_group(g, k, p_end);
      if (g == abort_at) begin
        offer(8'h3C);
        chk("t6_active_pre", 32'(active), 32'd1);
        chk("t6_ready_pre", 32'(tx_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_oe_reset", 32'(dut_oe), 32'd0);
        chk("t6_ready_reset", 32'(tx_ready), 32'd1);
        chk("t6_active_reset", 32'(active), 32'd0);
        hold_full = 1'b0;
        exp_tx.delete();
        @(negedge clk);
        cs = 1'b1; sck = p_pol; dq_i = 4'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_rx_none", 32'(rx_exp.size()), 32'd0);
        return;
      end
      if (!p_pha) begin
        dq_i = grp;
        repeat ((g == 0) ? 8 : h) @(negedge clk);
      end else begin
        repeat ((g == 0) ? 8 : h) @(negedge clk);
        sck = ~p_pol;
        if (pend) begin model_load(); pend = 1'b0; end
        dq_i = grp;
        repeat (h) @(negedge clk);
      end
      // sample edge: initiator captures target data
      grp_o = (k == 1) ? {3'b0, dut_o[1]} : (dut_o & mask);
      cb = p_end ? 8'((cb >> k) | (8'(grp_o) << (8 - k))) : 8'((cb << k) | 8'(grp_o));
      sck = p_pha ? p_pol : ~p_pol;
      bits += k;
      if (bits % 8 == 0) begin
        pend = 1'b1;
        if (rx_en) rx_exp.push_back(mosi[bits / 8 - 1]);
        if (chk_tx) begin
          if (exp_tx.size() == 0) fail("tx_model_empty", 32'(cb));
          else chk("tx_byte", 32'(cb), 32'(exp_tx.pop_front()));
          cap[cap_n] = cb;
          cap_n++;
        end
      end
      if (!p_pha) begin
        repeat (h) @(negedge clk);
        sck = p_pol;
        if (pend) begin model_load(); pend = 1'b0; end
      end
    end
    repeat (h) @(negedge clk);
    cs = 1'b1;
    dq_i = 4'b0;
    if (bits % 8 != 0) exp_par++;
    repeat (10) @(negedge clk);
    chk("underrun_cnt", 32'(dut_und), 32'(exp_und));
    chk("partial_cnt", 32'(dut_par), 32'(exp_par));
    chk("rx_pending", 32'(rx_exp.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(dut_oe), 32'd0);
    chk("rst_dq_o", 32'(dut_o), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_bits", 32'(rx_bits), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_partial", 32'(partial), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // T1: mode 0, single, MSB first
    offer(8'hA5);
    mosi[0] = 8'h3C;
    run_frame(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8, 6, 1'b1, -1);
    chk("t1_rx_lit", 32'(last_rx), 32'h3C);
    chk("t1_tx_lit", 32'(cap[0]), 32'hA5);

    // T2: mode 3, quad receive, LSB first
    mosi[0] = 8'hE1;
    run_frame(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8, 6, 1'b0, -1);
    chk("t2_rx_lit", 32'(last_rx), 32'hE1);

    // T3: mode 1, quad drive, second byte underruns
    offer(8'h5A);
    und0 = dut_und;
    mosi[0] = 8'h00; mosi[1] = 8'h00;
    run_frame(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 16, 6, 1'b1, -1);
    chk("t3_tx0_lit", 32'(cap[0]), 32'h5A);
    chk("t3_tx1_lit", 32'(cap[1]), 32'hFF);
    chk("t3_underrun_lit", 32'(dut_und - und0), 32'd1);

    // T4: release after 3 bits, then a clean byte
    mosi[0] = 8'hE0;
    run_frame(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3, 6, 1'b0, -1);
    mosi[0] = 8'h81;
    run_frame(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8, 6, 1'b0, -1);
    chk("t4_rx_lit", 32'(last_rx), 32'h81);

    // T5: four back-to-back bytes at clock/4
    rx0 = rx_cnt;
    mosi[0] = 8'h00; mosi[1] = 8'hFF; mosi[2] = 8'h55; mosi[3] = 8'hAA;
    run_frame(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32, 2, 1'b0, -1);
    chk("t5_rx_count", 32'(rx_cnt - rx0), 32'd4);
    chk("t5_last_lit", 32'(last_rx), 32'hAA);

    // T6: reset mid-byte, then a clean frame
    offer(8'hC3);
    mosi[0] = 8'hF0;
    run_frame(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8, 6, 1'b0, 3);
    offer(8'h96);
    mosi[0] = 8'h42;
    run_frame(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8, 6, 1'b1, -1);
    chk("t6_tx_lit", 32'(cap[0]), 32'h96);
    chk("t6_rx_lit", 32'(last_rx), 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
